// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: splits the HPS ioctl ROM byte stream into four core ROM
// regions and owns the core reset until a complete, valid image has loaded.
// Latency: dn_* outputs are registered, one cycle after the ioctl_wr sample;
// no backpressure, one byte strobe per cycle is always accepted.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN adds an 8-bit additive checksum
// check against EXP_SUM; without it err_sum is tied low.
// Ports:
//   clk_sys, reset         - single clock, synchronous active-high reset
//   ioctl_download/wr/addr/dout - HPS download stream
//   user_reset             - menu/button reset request, honoured in HOLD/RUN
//   dn_wr/region/addr/data - registered one-hot region write port to the core
//   core_reset             - registered reset to the core
//   rom_ok/err_len/err_sum - status of the last load
module rom_load_sequencer #(
  parameter int unsigned ADDR_W      = 17,
  parameter logic [24:0] R1_BASE     = 25'h06000,
  parameter logic [24:0] R2_BASE     = 25'h08000,
  parameter logic [24:0] R3_BASE     = 25'h0A000,
  parameter logic [24:0] TOTAL_LEN   = 25'h0A040,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [7:0]  EXP_SUM     = 8'h00
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              user_reset,
  output logic              dn_wr,
  output logic [3:0]        dn_region,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              core_reset,
  output logic              rom_ok,
  output logic              err_len,
  output logic              err_sum
);

  // Hold timer counts 0 .. HOLD_CYCLES-1; expiry on the last count.
  localparam int unsigned   TW     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              dl_q, dl_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              chk_q, chk_d;
  logic              core_reset_q, core_reset_d;
  logic              dn_wr_q, dn_wr_d;
  logic [3:0]        dn_region_q, dn_region_d;
  logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
  logic [7:0]        dn_data_q, dn_data_d;
  logic              rom_ok_q, rom_ok_d;
  logic              err_len_q, err_len_d;
  logic              err_sum_d;
  logic              dl_rise, dl_fall;
  logic              go_load;
  logic              load_err;
  logic [24:0]       base;
  logic [3:0]        region;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_sum_q;
`else
  // Only referenced so the parameter is not reported as dangling.
  logic unused_exp_sum;
  assign unused_exp_sum = ^EXP_SUM;
`endif

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  // Region decode on the incoming address.
  always_comb begin
    base   = 25'd0;
    region = 4'b0001;
    if (ioctl_addr < R1_BASE) begin
      base   = 25'd0;
      region = 4'b0001;
    end else if (ioctl_addr < R2_BASE) begin
      base   = R1_BASE;
      region = 4'b0010;
    end else if (ioctl_addr < R3_BASE) begin
      base   = R2_BASE;
      region = 4'b0100;
    end else begin
      base   = R3_BASE;
      region = 4'b1000;
    end
  end

  always_comb begin
    state_d      = state_q;
    dl_d         = ioctl_download;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    chk_d        = 1'b0;
    dn_wr_d      = 1'b0;
    dn_region_d  = 4'b0000;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    rom_ok_d     = rom_ok_q;
    err_len_d    = err_len_q;
    go_load      = 1'b0;
    load_err     = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    err_sum_d    = err_sum_q;
`else
    err_sum_d    = 1'b0;
`endif
    // Registered from the current state so the core sees the change one
    // cycle after the state register moves.
    core_reset_d = (state_q != S_RUN);

    case (state_q)
      S_IDLE: begin
        if (dl_rise) go_load = 1'b1;
      end

      S_LOAD: begin
        // A write coinciding with the download fall still lands before HOLD.
        if (ioctl_wr) begin
          if (ioctl_addr < TOTAL_LEN) begin
            dn_wr_d     = 1'b1;
            dn_region_d = region;
            dn_addr_d   = ADDR_W'(ioctl_addr - base);
            dn_data_d   = ioctl_dout;
            if (cnt_q != {ADDR_W{1'b1}}) cnt_d = cnt_q + ADDR_W'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_d = sum_q + ioctl_dout;
`endif
          end else begin
            err_len_d = 1'b1;
          end
        end
        if (dl_fall) begin
          state_d = S_HOLD;
          timer_d = '0;
          chk_d   = 1'b1;
        end
      end

      S_HOLD: begin
        // Image checks only on the first cycle after a load, not after a
        // user reset.
        if (chk_q) begin
          if (25'(cnt_q) != TOTAL_LEN) err_len_d = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
          if (sum_q != EXP_SUM) err_sum_d = 1'b1;
`endif
        end
        load_err = err_len_d | err_sum_d;
        if (user_reset) begin
          timer_d = '0;
        end else if (timer_q == T_LAST) begin
          if (load_err) begin
            state_d  = S_IDLE;
            rom_ok_d = 1'b0;
          end else begin
            state_d  = S_RUN;
            rom_ok_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_RUN: begin
        if (dl_rise) begin
          go_load = 1'b1;
        end else if (user_reset) begin
          state_d = S_HOLD;
          timer_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (go_load) begin
      state_d   = S_LOAD;
      cnt_d     = '0;
      err_len_d = 1'b0;
      rom_ok_d  = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_d     = 8'h00;
      err_sum_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dl_q         <= 1'b0;
      cnt_q        <= '0;
      timer_q      <= '0;
      chk_q        <= 1'b0;
      core_reset_q <= 1'b1;
      dn_wr_q      <= 1'b0;
      dn_region_q  <= 4'b0000;
      dn_addr_q    <= '0;
      dn_data_q    <= 8'h00;
      rom_ok_q     <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      chk_q        <= chk_d;
      core_reset_q <= core_reset_d;
      dn_wr_q      <= dn_wr_d;
      dn_region_q  <= dn_region_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      rom_ok_q     <= rom_ok_d;
      err_len_q    <= err_len_d;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q     <= 8'h00;
      err_sum_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      err_sum_q <= err_sum_d;
    end
  end
  assign err_sum = err_sum_q;
`else
  assign err_sum = 1'b0;
`endif

  assign dn_wr      = dn_wr_q;
  assign dn_region  = dn_region_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign core_reset = core_reset_q;
  assign rom_ok     = rom_ok_q;
  assign err_len    = err_len_q;

endmodule
